// File: rtl/move_special_seq_pkg.sv
// Shared state encoding, error codes and default opcode constants for the
// move-from-special fetch/execute sequencer.
package move_special_seq_pkg;

    localparam int         OPW_DEF      = 5;
    localparam logic [4:0] OPC_MFHI_DEF = 5'b11000;
    localparam logic [4:0] OPC_MFLO_DEF = 5'b11001;
    localparam logic [4:0] OPC_IN_DEF   = 5'b10110;
    localparam int         TMO_W_DEF    = 4;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_e;

endpackage

// File: rtl/mss_src_decode.sv
// Opcode to source-select decoder for the move-from-special class.
// The three source selects are kept one-hot even if two opcode constants collide.
module mss_src_decode
    import move_special_seq_pkg::*;
#(
    parameter int             OPW      = OPW_DEF,
    parameter logic [OPW-1:0] OPC_MFHI = OPC_MFHI_DEF,
    parameter logic [OPW-1:0] OPC_MFLO = OPC_MFLO_DEF,
    parameter logic [OPW-1:0] OPC_IN   = OPC_IN_DEF
) (
    input  logic [OPW-1:0] opcode_i,
    output logic           legal_o,
    output logic           hi_o,
    output logic           lo_o,
    output logic           in_o
);

    logic hit_hi;
    logic hit_lo;
    logic hit_in;

    assign hit_hi = (opcode_i == OPC_MFHI);
    assign hit_lo = (opcode_i == OPC_MFLO);
    assign hit_in = (opcode_i == OPC_IN);

    assign hi_o    = hit_hi;
    assign lo_o    = hit_lo & ~hit_hi;
    assign in_o    = hit_in & ~hit_hi & ~hit_lo;
    assign legal_o = hit_hi | hit_lo | hit_in;

endmodule

// File: rtl/move_special_seq.sv
// Fetch + move-from-special control sequencer: walks T0..T3, drives datapath
// strobes, with start/done handshake, memory-ready timeout and illegal-opcode exit.
module move_special_seq
    import move_special_seq_pkg::*;
#(
    parameter int             OPW      = OPW_DEF,
    parameter logic [OPW-1:0] OPC_MFHI = OPC_MFHI_DEF,
    parameter logic [OPW-1:0] OPC_MFLO = OPC_MFLO_DEF,
    parameter logic [OPW-1:0] OPC_IN   = OPC_IN_DEF,
    parameter int             TMO_W    = TMO_W_DEF,
    parameter int             FREE_RUN = 0
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           start_i,
    input  logic           mem_ready_i,
    input  logic [OPW-1:0] opcode_i,
    output logic           pc_out_o,
    output logic           mar_enable_o,
    output logic           zlow_in_o,
    output logic           inc_pc_o,
    output logic           zlow_out_o,
    output logic           pc_enable_o,
    output logic           mdr_read_o,
    output logic           mdr_enable_o,
    output logic           mdr_out_o,
    output logic           ir_enable_o,
    output logic           gra_o,
    output logic           r_in_o,
    output logic           hi_out_o,
    output logic           lo_out_o,
    output logic           inport_out_o,
    output logic           busy_o,
    output logic           done_o,
    output logic [1:0]     err_code_o
);

    localparam logic [TMO_W-1:0] TMO_MAX  = '1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - TMO_W'(1);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [1:0]       err_q, err_d;

    logic t0_q, t1_q, t2_q, t3_q;
    logic busy_q, done_q;

    logic src_legal, src_hi, src_lo, src_in;

    mss_src_decode #(
        .OPW      (OPW),
        .OPC_MFHI (OPC_MFHI),
        .OPC_MFLO (OPC_MFLO),
        .OPC_IN   (OPC_IN)
    ) u_src_decode (
        .opcode_i (opcode_i),
        .legal_o  (src_legal),
        .hi_o     (src_hi),
        .lo_o     (src_lo),
        .in_o     (src_in)
    );

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_T0;
                end
            end
            ST_T0: begin
                state_d   = ST_T1;
                tmo_cnt_d = '0;
            end
            ST_T1: begin
                if (mem_ready_i) begin
                    state_d = ST_T2;
                end else begin
                    // Saturating wait counter; the last allowed wait cycle exits to ERR.
                    if (tmo_cnt_q != TMO_MAX) begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
                    if (tmo_cnt_q >= TMO_LAST) begin
                        state_d = ST_ERR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
            end
            ST_T2: begin
                state_d = ST_T3;
            end
            ST_T3: begin
                if (src_legal) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ERR;
                    err_d   = ERR_ILLEGAL;
                end
            end
            ST_DONE: begin
                state_d = (FREE_RUN != 0) ? ST_T0 : ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_T0) begin
            err_d = ERR_OK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
            err_q     <= ERR_OK;
            t0_q      <= 1'b0;
            t1_q      <= 1'b0;
            t2_q      <= 1'b0;
            t3_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
            t0_q      <= (state_d == ST_T0);
            t1_q      <= (state_d == ST_T1);
            t2_q      <= (state_d == ST_T2);
            t3_q      <= (state_d == ST_T3);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign pc_out_o     = t0_q;
    assign mar_enable_o = t0_q;
    assign zlow_in_o    = t0_q;
    assign inc_pc_o     = t0_q;

    // Exit-cycle strobes follow the live handshake so the PC loads exactly once.
    assign mdr_read_o   = t1_q;
    assign mdr_enable_o = t1_q;
    assign zlow_out_o   = t1_q & mem_ready_i;
    assign pc_enable_o  = t1_q & mem_ready_i;

    assign mdr_out_o    = t2_q;
    assign ir_enable_o  = t2_q;

    // The opcode only settles once the IR has loaded, i.e. during T3 itself.
    assign gra_o        = t3_q & src_legal;
    assign r_in_o       = t3_q & src_legal;
    assign hi_out_o     = t3_q & src_hi;
    assign lo_out_o     = t3_q & src_lo;
    assign inport_out_o = t3_q & src_in;

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_code_o   = err_q;

endmodule

// File: tb/tb_move_special_seq.sv
// Randomized bench for move_special_seq: per-instruction expected strobe traces
// are derived from the phase timeline and compared every cycle.
module tb_move_special_seq;

    localparam logic [4:0] OP_HI = 5'b11000;
    localparam logic [4:0] OP_LO = 5'b11001;
    localparam logic [4:0] OP_IN = 5'b10110;
    localparam int         TMO_CYC = 15;

    typedef struct packed {
        logic       pc_out, mar_en, zlow_in, inc_pc;
        logic       zlow_out, pc_en, mdr_read, mdr_en;
        logic       mdr_out, ir_en;
        logic       gra, r_in, hi, lo, inport;
        logic       busy, done;
        logic [1:0] err;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        mem_ready = 1'b0;
    logic [4:0]  opcode = 5'd0;
    logic [18:0] v0, v1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    move_special_seq dut_std (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start0), .mem_ready_i(mem_ready), .opcode_i(opcode),
        .pc_out_o(v0[18]), .mar_enable_o(v0[17]), .zlow_in_o(v0[16]), .inc_pc_o(v0[15]),
        .zlow_out_o(v0[14]), .pc_enable_o(v0[13]), .mdr_read_o(v0[12]), .mdr_enable_o(v0[11]),
        .mdr_out_o(v0[10]), .ir_enable_o(v0[9]), .gra_o(v0[8]), .r_in_o(v0[7]),
        .hi_out_o(v0[6]), .lo_out_o(v0[5]), .inport_out_o(v0[4]),
        .busy_o(v0[3]), .done_o(v0[2]), .err_code_o(v0[1:0])
    );

    move_special_seq #(.FREE_RUN(1)) dut_fr (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .mem_ready_i(mem_ready), .opcode_i(opcode),
        .pc_out_o(v1[18]), .mar_enable_o(v1[17]), .zlow_in_o(v1[16]), .inc_pc_o(v1[15]),
        .zlow_out_o(v1[14]), .pc_enable_o(v1[13]), .mdr_read_o(v1[12]), .mdr_enable_o(v1[11]),
        .mdr_out_o(v1[10]), .ir_enable_o(v1[9]), .gra_o(v1[8]), .r_in_o(v1[7]),
        .hi_out_o(v1[6]), .lo_out_o(v1[5]), .inport_out_o(v1[4]),
        .busy_o(v1[3]), .done_o(v1[2]), .err_code_o(v1[1:0])
    );

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [4:0] op);
        return (op == OP_HI) || (op == OP_LO) || (op == OP_IN);
    endfunction

    function automatic logic [1:0] err_of(input logic [4:0] op, input int waits);
        if (waits >= TMO_CYC) return 2'b10;
        return is_legal(op) ? 2'b00 : 2'b01;
    endfunction

    // Cycle k counts from 1 = first T0 cycle of the instruction.
    function automatic obs_t expect_at(input int k, input logic [4:0] op, input int waits);
        obs_t e;
        e = '0;
        e.busy = 1'b1;
        if (k == 1) begin
            {e.pc_out, e.mar_en, e.zlow_in, e.inc_pc} = 4'hF;
        end else if (waits >= TMO_CYC) begin
            if (k <= 1 + TMO_CYC) {e.mdr_read, e.mdr_en} = 2'b11;
            else e.err = 2'b10;
        end else if (k < 2 + waits) begin
            {e.mdr_read, e.mdr_en} = 2'b11;
        end else if (k == 2 + waits) begin
            {e.mdr_read, e.mdr_en, e.zlow_out, e.pc_en} = 4'hF;
        end else if (k == 3 + waits) begin
            {e.mdr_out, e.ir_en} = 2'b11;
        end else if (k == 4 + waits) begin
            if (is_legal(op)) begin
                {e.gra, e.r_in} = 2'b11;
                e.hi     = (op == OP_HI);
                e.lo     = (op == OP_LO);
                e.inport = (op == OP_IN);
            end
        end else begin
            if (is_legal(op)) e.done = 1'b1;
            else e.err = 2'b01;
        end
        return e;
    endfunction

    task automatic set_start(input bit fr, input logic val);
        if (fr) start1 = val;
        else start0 = val;
    endtask

    task automatic instr(input bit fr, input logic [4:0] op, input int waits, input bit do_start);
        int  len;
        bit  in_t1;
        obs_t exp_v;
        opcode = op;
        if (do_start) begin
            @(posedge clk); #1;
            set_start(fr, 1'b1);
            mem_ready = 1'($urandom);
        end
        len = (waits >= TMO_CYC) ? TMO_CYC + 2 : waits + 5;
        for (int k = 1; k <= len; k++) begin
            @(posedge clk); #1;
            set_start(fr, 1'($urandom_range(0, 1)));
            in_t1 = (k >= 2) && (k <= 2 + waits) && (k <= 1 + TMO_CYC);
            mem_ready = in_t1 ? (k == 2 + waits) : 1'($urandom);
            @(negedge clk);
            exp_v = expect_at(k, op, waits);
            check($sformatf("%s op=%b w=%0d k=%0d", fr ? "fr" : "std", op, waits, k),
                  fr ? v1 : v0, exp_v);
        end
    endtask

    task automatic idle_check(input bit fr, input logic [1:0] err);
        @(posedge clk); #1;
        set_start(fr, 1'b0);
        mem_ready = 1'($urandom);
        @(negedge clk);
        check($sformatf("%s idle", fr ? "fr" : "std"), fr ? v1 : v0, {17'b0, err});
    endtask

    function automatic logic [4:0] legal_op();
        int r;
        r = $urandom_range(0, 2);
        return (r == 0) ? OP_HI : (r == 1) ? OP_LO : OP_IN;
    endfunction

    function automatic logic [4:0] illegal_op();
        logic [4:0] op;
        op = 5'($urandom);
        while (is_legal(op)) op = 5'($urandom);
        return op;
    endfunction

    initial begin
        logic [4:0] op;
        int         w;
        int         chain;

        // Reset and a mid-T1 asynchronous abort.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset std", v0, 19'd0);
        check("reset fr", v1, 19'd0);
        @(posedge clk); #1;
        opcode = OP_HI; start0 = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1 start0 = 1'b0;
        @(negedge clk);
        check("abort t0", v0, expect_at(1, OP_HI, 5));
        @(posedge clk); #1;
        @(negedge clk);
        check("abort t1", v0, expect_at(2, OP_HI, 5));
        #2 rst_n = 1'b0;
        #1 check("abort async", v0, 19'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort idle", v0, 19'd0);

        // Directed cases.
        instr(0, OP_HI, 0, 1);        idle_check(0, 2'b00);
        instr(0, OP_LO, 3, 1);        idle_check(0, 2'b00);
        instr(0, 5'b00000, 0, 1);     idle_check(0, 2'b01);
        instr(0, OP_HI, 15, 1);       idle_check(0, 2'b10);
        instr(0, OP_IN, 14, 1);       idle_check(0, 2'b00);
        instr(1, OP_IN, 0, 1);
        instr(1, OP_IN, 2, 0);
        instr(1, 5'b00000, 0, 0);     idle_check(1, 2'b01);

        // Randomized instruction mix.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                op = ($urandom_range(0, 2) != 0) ? legal_op() : 5'($urandom);
                w = $urandom_range(0, 9);
                w = (w < 6) ? w % 4 : (w < 8) ? 13 + (w - 6) : 15 + (w - 8);
                instr(0, op, w, 1);
                idle_check(0, err_of(op, w));
            end else begin
                chain = $urandom_range(1, 3);
                for (int i = 0; i < chain; i++)
                    instr(1, legal_op(), $urandom_range(0, 4), i == 0);
                if ($urandom_range(0, 1) != 0) begin
                    instr(1, illegal_op(), $urandom_range(0, 3), 0);
                    idle_check(1, 2'b01);
                end else begin
                    instr(1, legal_op(), 15, 0);
                    idle_check(1, 2'b10);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
